// File: rtl/data_store_serializer.sv
// Serializes a captured 32-bit word into 1/2/4 byte writes at consecutive addresses; N+1 cycles Start-to-Done.
// Backpressure: MemReady low in SEND holds every output unchanged for as long as it stays low.
module data_store_serializer #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [31:0]           Data,
    input  logic [ADDR_WIDTH-1:0] BaseAddr,
    input  logic [1:0]            Size,
    input  logic                  Order,
    input  logic                  MemReady,
    output logic                  MemWr,
    output logic [7:0]            ByteOut,
    output logic [ADDR_WIDTH-1:0] AddrOut,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             data_q, data_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [1:0]              last_q, last_d;
    logic                    order_q, order_d;
    logic [1:0]              idx_q, idx_d;
    logic [7:0]              byte_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic                    wr_d;
    logic                    done_d;

    // Index of the final byte, so the width select and the end test share one value.
    function automatic logic [1:0] size_last(input logic [1:0] sz);
        case (sz)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Big-endian mirrors the index within the selected width, not within the full word.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] last,
                                             input logic big, input logic [1:0] idx);
        logic [1:0] pos;
        pos = big ? (last - idx) : idx;
        return w[{pos, 3'b000} +: 8];
    endfunction

    always_ff @(posedge Clock) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        base_d  = base_q;
        last_d  = last_q;
        order_d = order_q;
        idx_d   = idx_q;
        byte_d  = ByteOut;
        addr_d  = AddrOut;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (Start) begin
                    state_d = ST_SEND;
                    data_d  = Data;
                    base_d  = BaseAddr;
                    last_d  = size_last(Size);
                    order_d = Order;
                    idx_d   = 2'd0;
                    byte_d  = pick_byte(Data, size_last(Size), Order, 2'd0);
                    addr_d  = BaseAddr;
                end
            end
            ST_SEND: begin
                if (MemReady) begin
                    if (idx_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        byte_d = pick_byte(data_q, last_q, order_q, idx_d);
                        addr_d = base_q + {{(ADDR_WIDTH-2){1'b0}}, idx_d};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wr_d   = (state_d == ST_SEND);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            data_q  <= '0;
            base_q  <= '0;
            last_q  <= '0;
            order_q <= 1'b0;
            idx_q   <= '0;
            MemWr   <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            ByteOut <= '0;
            AddrOut <= '0;
        end else begin
            data_q  <= data_d;
            base_q  <= base_d;
            last_q  <= last_d;
            order_q <= order_d;
            idx_q   <= idx_d;
            MemWr   <= wr_d;
            Busy    <= wr_d;
            Done    <= done_d;
            ByteOut <= byte_d;
            AddrOut <= addr_d;
        end
    end

endmodule

// File: tb/tb_data_store_serializer.sv
// Directed bench for data_store_serializer: hand-computed byte/address sequences.
module tb_data_store_serializer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] Data;
    logic [15:0] BaseAddr;
    logic [1:0]  Size;
    logic        Order;
    logic        MemReady;
    logic        MemWr;
    logic [7:0]  ByteOut;
    logic [15:0] AddrOut;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;

    data_store_serializer #(.ADDR_WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Data(Data),
        .BaseAddr(BaseAddr), .Size(Size), .Order(Order), .MemReady(MemReady),
        .MemWr(MemWr), .ByteOut(ByteOut), .AddrOut(AddrOut), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic wr, input logic [15:0] addr,
                              input logic [7:0] byt, input logic busy, input logic done);
        chk({tag, ".wr"},   {31'd0, MemWr}, {31'd0, wr});
        chk({tag, ".addr"}, {16'd0, AddrOut}, {16'd0, addr});
        chk({tag, ".byte"}, {24'd0, ByteOut}, {24'd0, byt});
        chk({tag, ".busy"}, {31'd0, Busy},  {31'd0, busy});
        chk({tag, ".done"}, {31'd0, Done},  {31'd0, done});
    endtask

    initial begin
        // Reset dominates a simultaneous Start.
        Reset = 1'b0; Start = 1'b1; Data = 32'hDEADBEEF; BaseAddr = 16'h1234;
        Size = 2'b10; Order = 1'b0; MemReady = 1'b1;
        tick();
        tick();
        expect_out("rst", 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        Reset = 1'b1; Start = 1'b0;
        tick();
        expect_out("rst_rel", 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);

        // 4-byte little-endian.
        Start = 1'b1; Data = 32'h11223344; BaseAddr = 16'h0100; Size = 2'b10; Order = 1'b0;
        tick();
        Start = 1'b0;
        expect_out("le4_b0", 1'b1, 16'h0100, 8'h44, 1'b1, 1'b0);
        tick();
        expect_out("le4_b1", 1'b1, 16'h0101, 8'h33, 1'b1, 1'b0);
        tick();
        expect_out("le4_b2", 1'b1, 16'h0102, 8'h22, 1'b1, 1'b0);
        tick();
        expect_out("le4_b3", 1'b1, 16'h0103, 8'h11, 1'b1, 1'b0);
        tick();
        expect_out("le4_done", 1'b0, 16'h0103, 8'h11, 1'b0, 1'b1);
        tick();
        expect_out("le4_idle", 1'b0, 16'h0103, 8'h11, 1'b0, 1'b0);

        // 2-byte big-endian with two wait states on the first byte.
        Start = 1'b1; Data = 32'hAABBCCDD; BaseAddr = 16'h0020; Size = 2'b01; Order = 1'b1;
        MemReady = 1'b0;
        tick();
        Start = 1'b0;
        expect_out("be2_w0", 1'b1, 16'h0020, 8'hCC, 1'b1, 1'b0);
        tick();
        expect_out("be2_w1", 1'b1, 16'h0020, 8'hCC, 1'b1, 1'b0);
        tick();
        expect_out("be2_w2", 1'b1, 16'h0020, 8'hCC, 1'b1, 1'b0);
        MemReady = 1'b1;
        tick();
        expect_out("be2_b1", 1'b1, 16'h0021, 8'hDD, 1'b1, 1'b0);
        tick();
        expect_out("be2_done", 1'b0, 16'h0021, 8'hDD, 1'b0, 1'b1);
        tick();

        // 1-byte at the top of the address space.
        Start = 1'b1; Data = 32'h000000A5; BaseAddr = 16'hFFFF; Size = 2'b00; Order = 1'b0;
        tick();
        Start = 1'b0;
        expect_out("b1_b0", 1'b1, 16'hFFFF, 8'hA5, 1'b1, 1'b0);
        tick();
        expect_out("b1_done", 1'b0, 16'hFFFF, 8'hA5, 1'b0, 1'b1);

        // Start in DONE: wrapping 2-byte store begins with no idle cycle.
        Start = 1'b1; Data = 32'h00001234; BaseAddr = 16'hFFFF; Size = 2'b01; Order = 1'b0;
        tick();
        expect_out("wrap_b0", 1'b1, 16'hFFFF, 8'h34, 1'b1, 1'b0);
        // Start during SEND with new operands must be ignored.
        Start = 1'b1; Data = 32'h99999999; BaseAddr = 16'h5555; Size = 2'b10; Order = 1'b1;
        tick();
        Start = 1'b0;
        expect_out("wrap_b1", 1'b1, 16'h0000, 8'h12, 1'b1, 1'b0);
        tick();
        expect_out("wrap_done", 1'b0, 16'h0000, 8'h12, 1'b0, 1'b1);
        tick();
        expect_out("wrap_idle", 1'b0, 16'h0000, 8'h12, 1'b0, 1'b0);

        // Reset after the 2nd byte of a 4-byte big-endian store.
        Start = 1'b1; Data = 32'h01020304; BaseAddr = 16'h0200; Size = 2'b11; Order = 1'b1;
        tick();
        Start = 1'b0;
        expect_out("mid_b0", 1'b1, 16'h0200, 8'h01, 1'b1, 1'b0);
        tick();
        expect_out("mid_b1", 1'b1, 16'h0201, 8'h02, 1'b1, 1'b0);
        Reset = 1'b0;
        tick();
        expect_out("mid_rst", 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        Reset = 1'b1;
        tick();
        expect_out("mid_after0", 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        tick();
        expect_out("mid_after1", 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
